grid8_valve_sequencer: RTL and testbench
========================================

GRID8_VALVE_SEQUENCER -- requirements
Module: grid8_valve_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles held after any valve change before the next change (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the settle/dwell counter.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  sequencer accepts command this cycle.
REQ-007 cmd_src  in  3  MUX8 input to route (0..7 = i1..i8).
REQ-008 cmd_stage  in  3  GRID stage to actuate (0..7 = g1..g8).
REQ-009 cmd_op  in  2  0=forward (d valves), 1=lateral (e valves), 2=both, 3=purge (stage valves only, mux closed).
REQ-010 cmd_dwell  in  8  flow cycles; 0 treated as 1.
REQ-011 c  out  6  MUX8 control lines c1..c6 (bit0=c1); 1 = valve open.
REQ-012 d  out  8  GRID forward-valve lines d1..d8; 1 = open.
REQ-013 e  out  8  GRID lateral-valve lines e1..e8; 1 = open.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse at completion of a command.

Function
REQ-016 cmd_ready SHALL equal (state==IDLE); accept on cmd_valid&&cmd_ready; fields latched at acceptance, later input changes ignored.
REQ-017 States SHALL be IDLE, CLOSE, ROUTE, FLOW, RELEASE; acceptance: IDLE->CLOSE.
REQ-018 CLOSE: c, d, e all 0 for SETTLE_CYCLES cycles, then ->ROUTE (break-before-make).
REQ-019 ROUTE: c = mux code of latched src (c1=~src[0], c2=src[0], c3=~src[1], c4=src[1], c5=~src[2], c6=src[2]), d=e=0, for SETTLE_CYCLES, then ->FLOW; op 3 drives c=0 in ROUTE.
REQ-020 FLOW: c held; d[stage]=1 if op∈{0,2,3}; e[stage]=1 if op∈{1,2,3}; other bits 0; lasts max(dwell,1) cycles, then ->RELEASE.
REQ-021 RELEASE: d=e=0, c held, for SETTLE_CYCLES, then ->IDLE with done=1 in the first IDLE cycle.
REQ-022 At most one d bit and one e bit SHALL be 1 in any cycle; c SHALL never have both bits of a pair (c1/c2, c3/c4, c5/c6) set.
REQ-023 All outputs SHALL be registered (no combinational path from cmd_* to c/d/e).
REQ-024 Counter SHALL load on each state entry and count down to 0; transition on the cycle count==0 (CLOSE/ROUTE/RELEASE each last exactly SETTLE_CYCLES cycles).
REQ-025 Accepted-to-done latency SHALL be 3*SETTLE_CYCLES + max(dwell,1) + 1 cycles.
REQ-026 Back-to-back: cmd_valid held high SHALL be accepted in the done cycle; new command always passes CLOSE first.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, c=0, d=0, e=0, busy=0, done=0, counter=0, latched fields=0.
REQ-028 Reset mid-command SHALL abandon the command with no done pulse; all valves closed asynchronously.
REQ-029 First acceptance possible on first rising edge after rst_n deasserts (cmd_ready=1 out of reset).

Configuration
REQ-030 Macro GRID_SEQ_ABORT_EN SHALL, when defined, add input abort (1 bit): abort high in ROUTE or FLOW forces ->RELEASE next cycle with c/d/e behaviour of RELEASE; done still pulses; abort ignored in IDLE, CLOSE, RELEASE.
REQ-031 Without GRID_SEQ_ABORT_EN, no abort port exists and commands always run to completion.

Verification
REQ-032 Reset: rst_n=0 while in FLOW with d[3]=1 -> d,e,c=0 same cycle, busy=0, no done.
REQ-033 SETTLE_CYCLES=4, src=5, stage=2, op=0, dwell=10 -> c=6'b100110 during ROUTE/FLOW/RELEASE, d=8'h04 for exactly 10 cycles, done 23 cycles after acceptance.
REQ-034 op=2, dwell=0, stage=7 -> d=e=8'h80 for exactly 1 cycle.
REQ-035 op=3, src=1 -> c=0 throughout, d[stage]=e[stage]=1 during FLOW.
REQ-036 cmd_valid held high with 2 commands -> second accepted in done cycle, all valves 0 for 4 CLOSE cycles between FLOWs.
REQ-037 GRID_SEQ_ABORT_EN, abort pulse at FLOW cycle 3 of dwell=50 -> RELEASE next cycle, done after 4 more cycles; abort in IDLE -> no effect.

Source files
------------

// File: rtl/grid8_valve_sequencer.sv
// Break-before-make valve sequencer: MUX8 source routing feeding one GRID8 stage.
// Optional `define GRID_SEQ_ABORT_EN adds an abort input that cuts ROUTE/FLOW short into RELEASE.
module grid8_valve_sequencer #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef GRID_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_src,
    input  logic [2:0] cmd_stage,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_dwell,
    output logic [5:0] c,
    output logic [7:0] d,
    output logic [7:0] e,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, CLOSE, ROUTE, FLOW, RELEASE} state_t;

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] stage;
        logic [1:0] op;
        logic [7:0] dwell;
    } cmd_t;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       OP_FWD    = 2'd0;
    localparam logic [1:0]       OP_LAT    = 2'd1;
    localparam logic [1:0]       OP_PURGE  = 2'd3;

    state_t           state, nxt_state;
    cmd_t             cmd_q, nxt_cmd;
    logic [CNT_W-1:0] cnt, nxt_cnt, dwell_ld;
    logic [5:0]       nxt_c, route_c;
    logic [7:0]       nxt_d, nxt_e, flow_d, flow_e, stage_oh;
    logic             nxt_done, abort_req;

`ifdef GRID_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Each mux pair is driven complementary, so c1/c2, c3/c4, c5/c6 can never both open.
    assign route_c  = (cmd_q.op == OP_PURGE) ? 6'd0 :
                      {cmd_q.src[2], ~cmd_q.src[2], cmd_q.src[1], ~cmd_q.src[1],
                       cmd_q.src[0], ~cmd_q.src[0]};
    assign stage_oh = 8'd1 << cmd_q.stage;
    assign flow_d   = (cmd_q.op != OP_LAT) ? stage_oh : 8'd0;
    assign flow_e   = (cmd_q.op != OP_FWD) ? stage_oh : 8'd0;
    assign dwell_ld = (cmd_q.dwell == 8'd0) ? '0 : CNT_W'(cmd_q.dwell - 8'd1);

    // Next-state logic also computes next output values so c/d/e/done leave flops.
    always_comb begin
        nxt_state = state;
        nxt_cmd   = cmd_q;
        nxt_cnt   = cnt;
        nxt_c     = c;
        nxt_d     = 8'd0;
        nxt_e     = 8'd0;
        nxt_done  = 1'b0;
        case (state)
            IDLE: begin
                nxt_c = 6'd0;
                if (cmd_valid) begin
                    nxt_state = CLOSE;
                    nxt_cnt   = SETTLE_LD;
                    nxt_cmd   = '{src: cmd_src, stage: cmd_stage, op: cmd_op, dwell: cmd_dwell};
                end
            end
            CLOSE: begin
                nxt_c = 6'd0;
                if (cnt == '0) begin
                    nxt_state = ROUTE;
                    nxt_cnt   = SETTLE_LD;
                    nxt_c     = route_c;
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                end
            end
            ROUTE: begin
                if (abort_req) begin
                    nxt_state = RELEASE;
                    nxt_cnt   = SETTLE_LD;
                end else if (cnt == '0) begin
                    nxt_state = FLOW;
                    nxt_cnt   = dwell_ld;
                    nxt_d     = flow_d;
                    nxt_e     = flow_e;
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                end
            end
            FLOW: begin
                if (abort_req || cnt == '0) begin
                    nxt_state = RELEASE;
                    nxt_cnt   = SETTLE_LD;
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                    nxt_d   = flow_d;
                    nxt_e   = flow_e;
                end
            end
            RELEASE: begin
                if (cnt == '0) begin
                    nxt_state = IDLE;
                    nxt_done  = 1'b1;
                    nxt_c     = 6'd0;
                end else begin
                    nxt_cnt = cnt - CNT_ONE;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
                nxt_c     = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cmd_q <= '0;
            cnt   <= '0;
            c     <= 6'd0;
            d     <= 8'd0;
            e     <= 8'd0;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            cmd_q <= nxt_cmd;
            cnt   <= nxt_cnt;
            c     <= nxt_c;
            d     <= nxt_d;
            e     <= nxt_e;
            done  <= nxt_done;
        end
    end
endmodule

// File: tb/tb_grid8_valve_sequencer.sv
// Directed bench for grid8_valve_sequencer: expected per-command results are queued
// when a command is driven and checked by a monitor when the DUT pulses done.
module tb_grid8_valve_sequencer;
    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_src;
    logic [2:0] cmd_stage;
    logic [1:0] cmd_op;
    logic [7:0] cmd_dwell;
    logic [5:0] c;
    logic [7:0] d;
    logic [7:0] e;
    logic       busy;
    logic       done;
`ifdef GRID_SEQ_ABORT_EN
    logic       abort;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         lat;
        int         flow;
        logic [7:0] d;
        logic [7:0] e;
        logic [5:0] c;
        int         ccyc;
        int         pre;
    } exp_t;

    exp_t sb[$];

    grid8_valve_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef GRID_SEQ_ABORT_EN
        .abort(abort),
`endif
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_src(cmd_src),
        .cmd_stage(cmd_stage),
        .cmd_op(cmd_op),
        .cmd_dwell(cmd_dwell),
        .c(c),
        .d(d),
        .e(e),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] s, input logic [2:0] st,
                                   input logic [1:0] o, input logic [7:0] dw);
        exp_t x;
        int dwe;
        dwe    = (dw == 8'd0) ? 1 : int'(dw);
        x.lat  = 3 * S + dwe + 1;
        x.flow = dwe;
        x.d    = (o != 2'd1) ? 8'(1 << st) : 8'h00;
        x.e    = (o != 2'd0) ? 8'(1 << st) : 8'h00;
        x.c    = 6'd0;
        if (o != 2'd3)
            for (int k = 0; k < 3; k++) begin
                x.c[2*k]   = ~s[k];
                x.c[2*k+1] = s[k];
            end
        x.ccyc = (o == 2'd3) ? 0 : 2 * S + dwe;
        x.pre  = (o == 2'd3) ? 2 * S : S;
        return x;
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    bit         m_act = 1'b0;
    bit         m_seen;
    int         m_cyc, m_flow, m_ccyc, m_pre;
    logic [7:0] m_d, m_e;
    logic [5:0] m_c;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (m_act) begin
                m_act = 1'b0;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end else begin
            check("invariant", ($countones(d) <= 1) && ($countones(e) <= 1) &&
                  !(c[0] && c[1]) && !(c[2] && c[3]) && !(c[4] && c[5]) &&
                  (busy === !cmd_ready), 1);
            if (m_act) begin
                m_cyc++;
                if (done) begin
                    exp_t x;
                    m_act = 1'b0;
                    check("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        x = sb.pop_front();
                        check("latency", m_cyc, x.lat);
                        check("flow_cycles", m_flow, x.flow);
                        check("d_pattern", m_d, x.d);
                        check("e_pattern", m_e, x.e);
                        check("c_code", m_c, x.c);
                        check("c_cycles", m_ccyc, x.ccyc);
                        check("closed_before", m_pre, x.pre);
                    end
                end else begin
                    if ((d | e) != 8'd0) m_flow++;
                    if (c != 6'd0) m_ccyc++;
                    m_d |= d;
                    m_e |= e;
                    m_c |= c;
                    if (!m_seen) begin
                        if (c == 6'd0 && d == 8'd0 && e == 8'd0) m_pre++;
                        else m_seen = 1'b1;
                    end
                end
            end else begin
                check("idle_done", done, 0);
            end
            if (cmd_valid && cmd_ready) begin
                m_act = 1'b1; m_seen = 1'b0;
                m_cyc = 0; m_flow = 0; m_ccyc = 0; m_pre = 0;
                m_d = '0; m_e = '0; m_c = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] s, input logic [2:0] st, input logic [1:0] o,
                        input logic [7:0] dw, input bit push);
        int n = 0;
        while (!cmd_ready && n < 500) begin tick(); n++; end
        check("ready_wait", cmd_ready, 1);
        cmd_src = s; cmd_stage = st; cmd_op = o; cmd_dwell = dw; cmd_valid = 1'b1;
        if (push) sb.push_back(model(s, st, o, dw));
        tick();
        cmd_valid = 1'b0;
        // Scramble fields: the DUT must have latched them already.
        cmd_src = 3'($urandom); cmd_stage = 3'($urandom);
        cmd_op = 2'($urandom); cmd_dwell = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin tick(); n++; end
        check("idle_wait", busy, 0);
        tick();
    endtask

    task automatic wait_flow();
        int n = 0;
        while ((d | e) == 8'd0 && n < 200) begin tick(); n++; end
        check("flow_wait", (d | e) != 8'd0, 1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0;
        cmd_src = '0; cmd_stage = '0; cmd_op = '0; cmd_dwell = '0;
`ifdef GRID_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #22;
        check("rst_c", c, 0);
        check("rst_d", d, 0);
        check("rst_e", e, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // src=5 stage=2 forward dwell=10: mux code 100110, d=04 for 10 cycles, done at +23.
        send(3'd5, 3'd2, 2'd0, 8'd10, 1);
        wait_flow();
        check("c_src5", c, 6'b100110);
        check("d_stage2", d, 8'h04);
        wait_idle();

        // Both valves, dwell 0 behaves as 1.
        send(3'd3, 3'd7, 2'd2, 8'd0, 1);
        wait_idle();

        // Purge: mux stays closed throughout.
        send(3'd1, 3'd4, 2'd3, 8'd6, 1);
        wait_flow();
        check("purge_c", c, 0);
        check("purge_de", {d, e}, {8'h10, 8'h10});
        wait_idle();

        // Back-to-back with cmd_valid held: second accepted in done cycle.
        begin
            int n = 0;
            cmd_src = 3'd3; cmd_stage = 3'd1; cmd_op = 2'd1; cmd_dwell = 8'd5; cmd_valid = 1'b1;
            sb.push_back(model(3'd3, 3'd1, 2'd1, 8'd5));
            tick();
            cmd_src = 3'd6; cmd_stage = 3'd5; cmd_op = 2'd2; cmd_dwell = 8'd2;
            sb.push_back(model(3'd6, 3'd5, 2'd2, 8'd2));
            while (!done && n < 200) begin tick(); n++; end
            check("b2b_done_ready", {done, cmd_ready}, 2'b11);
            tick();
            cmd_valid = 1'b0;
            check("b2b_second_busy", busy, 1);
            wait_idle();
        end

        for (int i = 0; i < 4; i++) begin
            send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)), 1);
            wait_idle();
        end

        // Reset during FLOW with d[3] open: valves close immediately, no done.
        send(3'd2, 3'd3, 2'd0, 8'd50, 1);
        wait_flow();
        tick(); tick();
        check("pre_rst_d", d, 8'h08);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cde", {c, d, e}, 22'd0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        check("post_rst_ready", cmd_ready, 1);
        send(3'd0, 3'd0, 2'd0, 8'd1, 1);
        wait_idle();

`ifdef GRID_SEQ_ABORT_EN
        // Abort in IDLE has no effect.
        abort = 1'b1;
        tick(); tick();
        check("abort_idle_busy", busy, 0);
        abort = 1'b0;
        // Abort on FLOW cycle 3 of dwell=50.
        begin
            exp_t x;
            x = model(3'd4, 3'd6, 2'd0, 8'd50);
            x.flow = 3; x.lat = 3 * S + 3 + 1; x.ccyc = 2 * S + 3;
            sb.push_back(x);
            send(3'd4, 3'd6, 2'd0, 8'd50, 0);
            wait_flow();
            tick(); tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_release_d", {busy, d}, {1'b1, 8'h00});
            wait_idle();
        end
`endif

        tick(); tick();
        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
